md_sequencer: RTL and testbench

//  Control FSM for the EX-stage multiply/divide units. It latches mult/multu/div/divu operands,

---
 rtl/md_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_md_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: EX-stage multiply/divide control FSM.
// Latches mult/multu/div/divu operands and drives the pipelined multiplier and
// the iterative divider. Raises the EX stall request while an operation is
// running, and presents {result_hi,result_lo} for the HI/LO write in DONE.
// Optional feature macro: MD_DIV0_FAST_EN. When it is defined, a divide by
// zero bypasses the divider and completes after a single stall cycle.
module md_sequencer #(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned DIV_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        pipe_hold,
    input  logic        op_valid,
    input  logic [3:0]  op_sel,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        stallreq,
    output logic        result_valid,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic        md_err,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    input  logic        div_ready,
    input  logic [63:0] div_result
);

    localparam int unsigned DW     = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TCNT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [TCNT_W-1:0]   tcnt, tcnt_nx;
    logic [DW-1:0]       op1_q, op1_nx;
    logic [DW-1:0]       op2_q, op2_nx;
    logic [DW-1:0]       hi_nx, lo_nx;
    logic                valid_nx, err_nx;
    logic                mul_signed_nx, div_signed_nx;
    logic                div_start_nx, div_annul_nx;
    logic                req, sel_mul;

    // A request needs exactly one opcode bit; multi-hot selects are no-ops
    assign req     = op_valid & $onehot(op_sel);
    assign sel_mul = |op_sel[3:2];

    assign mul_ina     = op1_q;
    assign mul_inb     = op2_q;
    assign div_opdata1 = op1_q;
    assign div_opdata2 = op2_q;

    // Stall EX while an instruction is being accepted or is running
    assign stallreq = ~rst & (((state == IDLE) & req) |
                              (state == MUL_WAIT) |
                              (state == DIV_RUN));

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        tcnt_nx       = tcnt;
        op1_nx        = op1_q;
        op2_nx        = op2_q;
        hi_nx         = result_hi;
        lo_nx         = result_lo;
        valid_nx      = 1'b0;
        err_nx        = 1'b0;
        mul_signed_nx = mul_signed;
        div_signed_nx = div_signed;
        div_start_nx  = 1'b0;
        div_annul_nx  = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    op1_nx = src1;
                    op2_nx = src2;
                    if (sel_mul) begin
                        mul_signed_nx = op_sel[3];
                        cnt_nx        = CNT_W'(MUL_LAT - 1);
                        state_nx      = MUL_WAIT;
                    end else begin
                        div_signed_nx = op_sel[1];
`ifdef MD_DIV0_FAST_EN
                        if (src2 == '0) begin
                            hi_nx    = src1;
                            lo_nx    = '1;
                            valid_nx = 1'b1;
                            state_nx = DONE;
                        end else begin
                            div_start_nx = 1'b1;
                            tcnt_nx      = '0;
                            state_nx     = DIV_RUN;
                        end
`else
                        div_start_nx = 1'b1;
                        tcnt_nx      = '0;
                        state_nx     = DIV_RUN;
`endif
                    end
                end
            end
            MUL_WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                end else begin
                    hi_nx    = mul_result[63:32];
                    lo_nx    = mul_result[31:0];
                    valid_nx = 1'b1;
                    state_nx = DONE;
                end
            end
            DIV_RUN: begin
                if (div_ready) begin
                    hi_nx    = div_result[63:32];
                    lo_nx    = div_result[31:0];
                    valid_nx = 1'b1;
                    state_nx = DONE;
                end else if (tcnt == TCNT_W'(DIV_TIMEOUT - 1)) begin
                    div_annul_nx = 1'b1;
                    hi_nx        = '0;
                    lo_nx        = '0;
                    err_nx       = 1'b1;
                    valid_nx     = 1'b1;
                    state_nx     = DONE;
                end else begin
                    div_start_nx = 1'b1;
                    tcnt_nx      = tcnt + TCNT_W'(1);
                end
            end
            DONE: begin
                if (pipe_hold) begin
                    valid_nx = 1'b1;
                    err_nx   = md_err;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Flush overrides everything; a running divide must be annulled
        if (flush) begin
            state_nx     = IDLE;
            valid_nx     = 1'b0;
            err_nx       = 1'b0;
            div_start_nx = 1'b0;
            div_annul_nx = (state == DIV_RUN);
        end
    end

    // State, counters, operands and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            tcnt         <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            result_hi    <= '0;
            result_lo    <= '0;
            result_valid <= 1'b0;
            md_err       <= 1'b0;
            mul_signed   <= 1'b0;
            div_signed   <= 1'b0;
            div_start    <= 1'b0;
            div_annul    <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            tcnt         <= tcnt_nx;
            op1_q        <= op1_nx;
            op2_q        <= op2_nx;
            result_hi    <= hi_nx;
            result_lo    <= lo_nx;
            result_valid <= valid_nx;
            md_err       <= err_nx;
            mul_signed   <= mul_signed_nx;
            div_signed   <= div_signed_nx;
            div_start    <= div_start_nx;
            div_annul    <= div_annul_nx;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: multiplier and divider models, scoreboard of
// expected {md_err, result_hi, result_lo}, directed steps in one initial block.
module tb_md_sequencer;

    localparam int unsigned MUL_LAT     = 2;
    localparam int unsigned DIV_TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst, flush, pipe_hold, op_valid;
    logic [3:0]  op_sel;
    logic [31:0] src1, src2;
    logic        stallreq, result_valid, md_err;
    logic [31:0] result_hi, result_lo;
    logic        mul_signed;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opdata1, div_opdata2;
    logic [63:0] div_result;

    int errors = 0;
    int checks = 0;
    logic [64:0] exp_q[$];

    int unsigned ready_after = 33;
    logic        ready_en = 1'b1;
    int unsigned dcnt;
    logic [63:0] ma, mb;

    md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .flush(flush), .pipe_hold(pipe_hold),
        .op_valid(op_valid), .op_sel(op_sel), .src1(src1), .src2(src2),
        .stallreq(stallreq), .result_valid(result_valid),
        .result_hi(result_hi), .result_lo(result_lo), .md_err(md_err),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_result(mul_result), .div_start(div_start), .div_signed(div_signed),
        .div_annul(div_annul), .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
        .div_ready(div_ready), .div_result(div_result)
    );

    always #5 clk = ~clk;

    // Multiplier model: one register stage, operands extended per signedness
    always_comb begin
        ma = mul_signed ? {{32{mul_ina[31]}}, mul_ina} : {32'b0, mul_ina};
        mb = mul_signed ? {{32{mul_inb[31]}}, mul_inb} : {32'b0, mul_inb};
    end
    always_ff @(posedge clk) mul_result <= ma * mb;

    // Divider model: ready in the ready_after-th cycle of div_start
    always_ff @(posedge clk) begin
        if (rst || !div_start) dcnt <= 0;
        else                   dcnt <= dcnt + 1;
    end
    assign div_ready = ready_en && div_start && (dcnt == ready_after - 1);

    always_comb begin
        if (div_opdata2 == 32'd0)
            div_result = {div_opdata1, 32'hFFFF_FFFF};
        else if (div_signed)
            div_result = {32'($signed(div_opdata1) % $signed(div_opdata2)),
                          32'($signed(div_opdata1) / $signed(div_opdata2))};
        else
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
    end

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for DONE, score it, then optionally hold in DONE
    task automatic run_op(input string tag, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [64:0] exp, input int exp_stall,
                          input int exp_start, input logic exp_annul, input int hold);
        int stall_n = 0;
        int start_n = 0;
        int n = 0;
        bit got = 0;
        logic [64:0] want;
        logic [64:0] seen;
        exp_q.push_back(exp);
        op_valid = 1'b1; op_sel = sel; src1 = a; src2 = b;
        while (!got && n < 200) begin
            #1;
            if (stallreq)     stall_n++;
            if (div_start)    start_n++;
            if (result_valid) got = 1;
            else begin cyc(); n++; end
        end
        check({tag, " done"}, 65'(got), 65'(1));
        check({tag, " stall_cycles"}, 65'(stall_n), 65'(exp_stall));
        check({tag, " div_start_cycles"}, 65'(start_n), 65'(exp_start));
        check({tag, " annul_at_done"}, 65'(div_annul), 65'(exp_annul));
        check({tag, " stall_in_done"}, 65'(stallreq), 65'(0));
        want = exp_q.pop_front();
        seen = {md_err, result_hi, result_lo};
        check({tag, " result"}, seen, want);
        if (hold == 0) begin
            op_valid = 1'b0;
        end else begin
            pipe_hold = 1'b1;
            for (int i = 0; i < hold; i++) begin
                cyc();
                if (i == hold - 1) begin pipe_hold = 1'b0; op_valid = 1'b0; end
                #1;
                check({tag, " hold_valid"}, 65'(result_valid), 65'(1));
                check({tag, " hold_result"}, {md_err, result_hi, result_lo}, want);
                check({tag, " hold_nostall"}, 65'(stallreq), 65'(0));
            end
        end
        cyc(); #1;
        check({tag, " valid_drop"}, 65'(result_valid), 65'(0));
        check({tag, " idle_nostall"}, 65'(stallreq), 65'(0));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pipe_hold = 1'b0;
        op_valid = 1'b1; op_sel = 4'b1000; src1 = 32'd7; src2 = 32'd9;
        cyc(); cyc(); #1;
        check("rst stallreq", 65'(stallreq), 65'(0));
        check("rst valid", 65'(result_valid), 65'(0));
        check("rst result", {md_err, result_hi, result_lo}, 65'(0));
        check("rst div_start", 65'(div_start), 65'(0));
        check("rst div_annul", 65'(div_annul), 65'(0));
        check("rst mul_ina", 65'(mul_ina), 65'(0));

        rst = 1'b0; op_valid = 1'b0; op_sel = 4'b0000;
        cyc();

        run_op("mult", 4'b1000, 32'hFFFF_FFFD, 32'd5,
               {1'b0, 64'hFFFF_FFFF_FFFF_FFF1}, 3, 0, 1'b0, 0);
        run_op("multu_hold", 4'b0100, 32'hFFFF_FFFF, 32'd2,
               {1'b0, 32'h0000_0001, 32'hFFFF_FFFE}, 3, 0, 1'b0, 3);
        run_op("divu", 4'b0001, 32'd100, 32'd7,
               {1'b0, 32'd2, 32'd14}, 34, 33, 1'b0, 0);
        run_op("div_signed", 4'b0010, 32'hFFFF_FFF9, 32'd2,
               {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 33, 1'b0, 0);
`ifdef MD_DIV0_FAST_EN
        run_op("div0_fast", 4'b0010, 32'd9, 32'd0,
               {1'b0, 32'd9, 32'hFFFF_FFFF}, 1, 0, 1'b0, 0);
`else
        run_op("div0", 4'b0010, 32'd9, 32'd0,
               {1'b0, 32'd9, 32'hFFFF_FFFF}, 34, 33, 1'b0, 0);
`endif

        // Divider never answers: timeout annuls and flags md_err
        ready_en = 1'b0;
        run_op("timeout", 4'b0001, 32'd5, 32'd1,
               {1'b1, 64'd0}, 41, 40, 1'b1, 0);
        ready_en = 1'b1;

        // Flush in DIV_RUN cycle 5
        op_valid = 1'b1; op_sel = 4'b0010; src1 = 32'd50; src2 = 32'd5;
        for (int i = 0; i < 5; i++) cyc();
        flush = 1'b1; op_valid = 1'b0; #1;
        check("flushdiv stall_before", 65'(stallreq), 65'(1));
        check("flushdiv start_before", 65'(div_start), 65'(1));
        cyc(); flush = 1'b0; #1;
        check("flushdiv annul", 65'(div_annul), 65'(1));
        check("flushdiv start_off", 65'(div_start), 65'(0));
        check("flushdiv valid", 65'(result_valid), 65'(0));
        check("flushdiv stall", 65'(stallreq), 65'(0));
        cyc(); #1;
        check("flushdiv annul_1cyc", 65'(div_annul), 65'(0));
        check("flushdiv valid_later", 65'(result_valid), 65'(0));

        // Flush in MUL_WAIT: no result, no annul
        op_valid = 1'b1; op_sel = 4'b1000; src1 = 32'd7; src2 = 32'd7;
        cyc();
        flush = 1'b1; op_valid = 1'b0;
        cyc(); flush = 1'b0; #1;
        check("flushmul valid", 65'(result_valid), 65'(0));
        check("flushmul annul", 65'(div_annul), 65'(0));
        check("flushmul stall", 65'(stallreq), 65'(0));
        cyc(); #1;
        check("flushmul valid_later", 65'(result_valid), 65'(0));

        // Multi-hot select is a no-op
        op_valid = 1'b1; op_sel = 4'b1100; src1 = 32'hDEAD_BEEF; src2 = 32'd3; #1;
        check("multihot stall", 65'(stallreq), 65'(0));
        cyc(); cyc(); #1;
        check("multihot stall_later", 65'(stallreq), 65'(0));
        check("multihot valid", 65'(result_valid), 65'(0));
        check("multihot no_latch", 65'(mul_ina), 65'(32'd7));
        op_valid = 1'b0; op_sel = 4'b0000;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
